// File: rtl/keccak_avst_host_pkg.sv
// Shared types and sizes for the SHA-3 stream host: FSM state encoding,
// message word / digest geometry and the first-byte remainder helper.
package keccak_avst_pkg;

    localparam int WORD_BYTES   = 4;
    localparam int DIGEST_BYTES = 64;
    localparam int WORD_W       = WORD_BYTES * 8;
    localparam int DIGEST_W     = DIGEST_BYTES * 8;
    localparam int MBYTES_W     = $clog2(WORD_BYTES);
    localparam int DCNT_W       = $clog2(DIGEST_BYTES);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_e;

    // Bytes left behind the byte presented when a word is loaded; msg_bytes of 0 means a full word.
    function automatic logic [MBYTES_W-1:0] rem_after_first(input logic last,
                                                            input logic [MBYTES_W-1:0] nbytes);
        if (last && nbytes != '0) return nbytes - 1'b1;
        return MBYTES_W'(WORD_BYTES - 1);
    endfunction

endpackage

// File: rtl/keccak_avst_host_if.sv
// Word-side, byte-stream, digest-stream and digest-result signals of the host.
// master = the host block, slave = CPU/DMA plus hash wrapper side.
interface keccak_avst_host_if;
    import keccak_avst_pkg::*;

    // Every channel transfers a beat when valid & ready are both high on a rising clk edge;
    // a source holds valid and its payload steady until that transfer happens.
    logic [WORD_W-1:0]   msg_data;
    logic                msg_valid;
    logic                msg_last;
    logic [MBYTES_W-1:0] msg_bytes;
    logic                msg_ready;
    logic [7:0]          st_data;
    logic                st_valid;
    logic                st_end;
    logic                st_ready;
    logic [7:0]          hs_data;
    logic                hs_valid;
    logic                hs_end;
    logic                hs_ready;
    logic [DIGEST_W-1:0] digest;
    logic                digest_valid;
    logic                digest_ack;

    modport master (
        input  msg_data, msg_valid, msg_last, msg_bytes,
        output msg_ready,
        output st_data, st_valid, st_end,
        input  st_ready,
        input  hs_data, hs_valid, hs_end,
        output hs_ready,
        output digest, digest_valid,
        input  digest_ack
    );

    modport slave (
        output msg_data, msg_valid, msg_last, msg_bytes,
        input  msg_ready,
        input  st_data, st_valid, st_end,
        output st_ready,
        output hs_data, hs_valid, hs_end,
        input  hs_ready,
        input  digest, digest_valid,
        output digest_ack
    );

endinterface

// File: rtl/keccak_avst_host_sipo.sv
// Digest collector: shifts accepted bytes in at the LSB end and flags the beat
// that carries the final digest byte.
module keccak_digest_sipo
    import keccak_avst_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                clr_i,
    input  logic                en_i,
    input  logic [7:0]          data_i,
    output logic [DIGEST_W-1:0] digest_o,
    output logic                full_o
);

    logic [DIGEST_W-1:0] digest_q;
    logic [DCNT_W-1:0]   cnt_q;

    // Combinational so the owner can register completion on the same edge as the last byte.
    assign full_o   = en_i && (cnt_q == DCNT_W'(DIGEST_BYTES - 1));
    assign digest_o = digest_q;

    // clr_i only restarts the count; the old digest stays readable until overwritten.
    always_ff @(posedge clk) begin
        if (reset) begin
            digest_q <= '0;
            cnt_q    <= '0;
        end else if (clr_i) begin
            cnt_q    <= '0;
        end else if (en_i) begin
            digest_q <= {digest_q[DIGEST_W-9:0], data_i};
            cnt_q    <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/keccak_avst_host.sv
// Host side of the byte-wide SHA-3 stream: serialises message words MSB-byte-first
// and gathers the 64-byte digest. KECCAK_HOST_CHECK_EN adds the sticky proto_err output.
module keccak_avst_host
    import keccak_avst_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    keccak_avst_host_if.master bus,
`ifdef KECCAK_HOST_CHECK_EN
    output logic               proto_err,
`endif
    output state_e             dbg_state_o
);

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   shift_q, shift_d, skid_q, skid_d;
    logic [MBYTES_W-1:0] rem_q, rem_d, skid_bytes_q, skid_bytes_d;
    logic                last_q, last_d, skid_last_q, skid_last_d, skid_full_q, skid_full_d;
    logic [7:0]          st_data_q, st_data_d;
    logic                st_valid_q, st_valid_d, st_end_q, st_end_d;
    logic                msg_ready_q, msg_ready_d, hs_ready_q, hs_ready_d, dvalid_q, dvalid_d;
    logic                msg_acc, st_xfer, hs_acc, hs_early, sipo_clr, sipo_full, do_load;
    logic [WORD_W-1:0]   ld_word;
    logic                ld_last;
    logic [MBYTES_W-1:0] ld_bytes, ld_rem;
    logic [DIGEST_W-1:0] digest_w;

    assign msg_acc = bus.msg_valid & msg_ready_q;
    assign st_xfer = st_valid_q & bus.st_ready;
    assign hs_acc  = bus.hs_valid & hs_ready_q;

    // A word waiting in the skid always goes out before anything on the bus.
    assign ld_word  = skid_full_q ? skid_q       : bus.msg_data;
    assign ld_last  = skid_full_q ? skid_last_q  : bus.msg_last;
    assign ld_bytes = skid_full_q ? skid_bytes_q : bus.msg_bytes;
    assign ld_rem   = rem_after_first(ld_last, ld_bytes);

`ifdef KECCAK_HOST_CHECK_EN
    logic err_q, err_d;
    assign hs_early  = (state_q == WAIT) & bus.hs_end & ~sipo_full;
    assign err_d     = err_q | hs_early | (bus.hs_valid & (state_q != WAIT));
    assign proto_err = err_q;
`else
    logic unused_hs_end;
    assign unused_hs_end = bus.hs_end;
    assign hs_early      = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        rem_d        = rem_q;
        last_d       = last_q;
        skid_d       = skid_q;
        skid_last_d  = skid_last_q;
        skid_bytes_d = skid_bytes_q;
        skid_full_d  = skid_full_q;
        st_data_d    = st_data_q;
        st_valid_d   = st_valid_q;
        st_end_d     = st_end_q;
        sipo_clr     = 1'b0;
        do_load      = 1'b0;
        case (state_q)
            IDLE: begin
                if (msg_acc) begin
                    do_load  = 1'b1;
                    sipo_clr = 1'b1;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (st_xfer && rem_q != '0) begin
                    st_data_d = shift_q[WORD_W-1 -: 8];
                    shift_d   = shift_q << 8;
                    rem_d     = rem_q - 1'b1;
                    st_end_d  = last_q && (rem_q == MBYTES_W'(1));
                end else if (st_xfer && last_q) begin
                    st_valid_d = 1'b0;
                    st_end_d   = 1'b0;
                    state_d    = WAIT;
                end else if (st_xfer || !st_valid_q) begin
                    if (skid_full_q || msg_acc) begin
                        do_load     = 1'b1;
                        skid_full_d = 1'b0;
                    end else begin
                        st_valid_d  = 1'b0;
                    end
                end else if (msg_acc) begin
                    // Word accepted while the current last byte is stalled: park it.
                    skid_d       = bus.msg_data;
                    skid_last_d  = bus.msg_last;
                    skid_bytes_d = bus.msg_bytes;
                    skid_full_d  = 1'b1;
                end
            end
            WAIT: begin
                if (sipo_full || hs_early) state_d = DONE;
            end
            DONE: begin
                if (bus.digest_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (do_load) begin
            st_data_d  = ld_word[WORD_W-1 -: 8];
            shift_d    = ld_word << 8;
            rem_d      = ld_rem;
            last_d     = ld_last;
            st_end_d   = ld_last && (ld_rem == '0);
            st_valid_d = 1'b1;
        end
        msg_ready_d = (state_d == IDLE) ||
                      ((state_d == SEND) && !last_d && (rem_d == '0) && !skid_full_d);
        hs_ready_d  = (state_d == WAIT);
        dvalid_d    = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            rem_q        <= '0;
            last_q       <= 1'b0;
            skid_q       <= '0;
            skid_last_q  <= 1'b0;
            skid_bytes_q <= '0;
            skid_full_q  <= 1'b0;
            st_data_q    <= '0;
            st_valid_q   <= 1'b0;
            st_end_q     <= 1'b0;
            msg_ready_q  <= 1'b1;
            hs_ready_q   <= 1'b0;
            dvalid_q     <= 1'b0;
`ifdef KECCAK_HOST_CHECK_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            rem_q        <= rem_d;
            last_q       <= last_d;
            skid_q       <= skid_d;
            skid_last_q  <= skid_last_d;
            skid_bytes_q <= skid_bytes_d;
            skid_full_q  <= skid_full_d;
            st_data_q    <= st_data_d;
            st_valid_q   <= st_valid_d;
            st_end_q     <= st_end_d;
            msg_ready_q  <= msg_ready_d;
            hs_ready_q   <= hs_ready_d;
            dvalid_q     <= dvalid_d;
`ifdef KECCAK_HOST_CHECK_EN
            err_q        <= err_d;
`endif
        end
    end

    keccak_digest_sipo u_sipo (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (sipo_clr),
        .en_i     (hs_acc),
        .data_i   (bus.hs_data),
        .digest_o (digest_w),
        .full_o   (sipo_full)
    );

    assign bus.msg_ready    = msg_ready_q;
    assign bus.st_data      = st_data_q;
    assign bus.st_valid     = st_valid_q;
    assign bus.st_end       = st_end_q;
    assign bus.hs_ready     = hs_ready_q;
    assign bus.digest       = digest_w;
    assign bus.digest_valid = dvalid_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_keccak_avst_host.sv
// Directed bench for keccak_avst_host: message serialisation, skid/stall behaviour,
// digest collection, reset mid-message and the KECCAK_HOST_CHECK_EN early-end case.
module tb_keccak_avst_host;
    import keccak_avst_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    keccak_avst_host_if bus();
    state_e dbg_state;
`ifdef KECCAK_HOST_CHECK_EN
    logic proto_err;
`endif

    keccak_avst_host dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
`ifdef KECCAK_HOST_CHECK_EN
        .proto_err   (proto_err),
`endif
        .dbg_state_o (dbg_state)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0]         w_tab [4];
    logic                l_tab [4];
    logic [1:0]          b_tab [4];
    int                  n_words;
    logic [7:0]          exp_q [$];
    logic [DIGEST_W-1:0] exp_dig;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DIGEST_W-1:0] obs,
                         input logic [DIGEST_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic present(input int idx);
        bus.msg_data  = w_tab[idx];
        bus.msg_last  = l_tab[idx];
        bus.msg_bytes = b_tab[idx];
        bus.msg_valid = 1'b1;
    endtask

    // Sends w_tab[0..n_words-1] and checks the byte stream against exp_q.
    task automatic stream(input bit toggle, input bit no_bubble);
        int widx;
        bit started, stalled, w_acc, first;
        logic [7:0] held_d, e;
        logic held_e;
        widx = 0;
        started = 0;
        present(0);
        for (int cyc = 0; cyc < 60 && exp_q.size() > 0; cyc++) begin
            bus.st_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
            stalled = 0;
            if (no_bubble && started) check("no_bubble", bus.st_valid, 1'b1);
            if (bus.st_valid && bus.st_ready) begin
                e = exp_q.pop_front();
                check("st_data", bus.st_data, e);
                check("st_end", bus.st_end, exp_q.size() == 0);
                started = 1;
            end else if (bus.st_valid) begin
                held_d = bus.st_data;
                held_e = bus.st_end;
                stalled = 1;
            end
            w_acc = bus.msg_valid && bus.msg_ready;
            first = w_acc && (widx == 0);
            tick();
            if (stalled) begin
                check("stall_valid", bus.st_valid, 1'b1);
                check("stall_data", bus.st_data, held_d);
                check("stall_end", bus.st_end, held_e);
            end
            if (first) check("first_latency", bus.st_valid, 1'b1);
            if (w_acc) begin
                widx++;
                if (widx < n_words) present(widx);
                else bus.msg_valid = 1'b0;
            end
        end
        check("stream_drained", exp_q.size(), 0);
        check("wait_st_valid", bus.st_valid, 1'b0);
        check("wait_hs_ready", bus.hs_ready, 1'b1);
        check("wait_state", dbg_state, WAIT);
    endtask

    task automatic feed(input int n, input logic [7:0] base, input bit completes);
        for (int k = 0; k < n; k++) begin
            bus.hs_data  = 8'(base + k);
            bus.hs_valid = 1'b1;
            exp_dig = {exp_dig[DIGEST_W-9:0], bus.hs_data};
            tick();
            check("dvalid_timing", bus.digest_valid, completes && (k == n - 1));
        end
        bus.hs_valid = 1'b0;
    endtask

    task automatic finish_digest();
        check("digest", bus.digest, exp_dig);
        check("dvalid_held", bus.digest_valid, 1'b1);
        check("done_msg_ready", bus.msg_ready, 1'b0);
        bus.digest_ack = 1'b1;
        tick();
        bus.digest_ack = 1'b0;
        check("ack_dvalid", bus.digest_valid, 1'b0);
        check("ack_msg_ready", bus.msg_ready, 1'b1);
        check("ack_state", dbg_state, IDLE);
    endtask

    initial begin
        bus.msg_data = '0; bus.msg_valid = 0; bus.msg_last = 0; bus.msg_bytes = '0;
        bus.st_ready = 0; bus.hs_data = '0; bus.hs_valid = 0; bus.hs_end = 0;
        bus.digest_ack = 0;
        exp_dig = '0;
        tick();
        tick();
        check("rst_msg_ready", bus.msg_ready, 1'b1);
        check("rst_st_valid", bus.st_valid, 1'b0);
        check("rst_st_end", bus.st_end, 1'b0);
        check("rst_st_data", bus.st_data, 8'h00);
        check("rst_hs_ready", bus.hs_ready, 1'b0);
        check("rst_digest", bus.digest, '0);
        check("rst_dvalid", bus.digest_valid, 1'b0);
        check("rst_state", dbg_state, IDLE);
`ifdef KECCAK_HOST_CHECK_EN
        check("rst_proto_err", proto_err, 1'b0);
`endif
        reset = 1'b0;
        tick();

        // "abc": three bytes, end marker on 0x63 only
        w_tab[0] = 32'h6162_6300; l_tab[0] = 1; b_tab[0] = 2'd3; n_words = 1;
        exp_q = '{8'h61, 8'h62, 8'h63};
        stream(0, 1);

        // digest_ack while waiting for the digest must be ignored
        bus.digest_ack = 1'b1;
        tick();
        bus.digest_ack = 1'b0;
        check("ack_ignored_state", dbg_state, WAIT);
        check("ack_ignored_hs_ready", bus.hs_ready, 1'b1);

        feed(64, 8'h00, 1);
        check("digest_ramp", bus.digest,
              512'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f202122232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f);
        bus.hs_end = 1'b1;
        tick();
        bus.hs_end = 1'b0;
        tick();
        finish_digest();

        // two words, partial last word, st_ready toggling
        w_tab[0] = 32'h0102_0304; l_tab[0] = 0; b_tab[0] = 2'd0;
        w_tab[1] = 32'h0506_0000; l_tab[1] = 1; b_tab[1] = 2'd2; n_words = 2;
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        stream(1, 0);
        feed(64, 8'h80, 1);
        finish_digest();

        // back-to-back full words, msg_valid held, no bubble at the word boundary
        w_tab[0] = 32'hAABB_CCDD; l_tab[0] = 0; b_tab[0] = 2'd0;
        w_tab[1] = 32'h1122_3344; l_tab[1] = 1; b_tab[1] = 2'd0; n_words = 2;
        exp_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
        stream(0, 1);
        feed(64, 8'h40, 1);
        finish_digest();

        // reset after two bytes have gone out
        w_tab[0] = 32'hDEAD_BEEF; l_tab[0] = 1; b_tab[0] = 2'd0; n_words = 1;
        present(0);
        bus.st_ready = 1'b1;
        tick();
        bus.msg_valid = 1'b0;
        tick();
        tick();
        check("pre_rst_st_data", bus.st_data, 8'hBE);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_dig = '0;
        check("mid_rst_msg_ready", bus.msg_ready, 1'b1);
        check("mid_rst_st_valid", bus.st_valid, 1'b0);
        check("mid_rst_digest", bus.digest, '0);
        check("mid_rst_dvalid", bus.digest_valid, 1'b0);
        check("mid_rst_state", dbg_state, IDLE);
        w_tab[0] = 32'h4100_0000; l_tab[0] = 1; b_tab[0] = 2'd1; n_words = 1;
        exp_q = '{8'h41};
        stream(0, 1);
        feed(64, 8'hC0, 1);
        finish_digest();

        // hs_end after only ten digest bytes
        w_tab[0] = 32'h7A00_0000; l_tab[0] = 1; b_tab[0] = 2'd1; n_words = 1;
        exp_q = '{8'h7A};
        stream(0, 1);
        feed(10, 8'h10, 0);
        bus.hs_end = 1'b1;
        tick();
        bus.hs_end = 1'b0;
`ifdef KECCAK_HOST_CHECK_EN
        check("early_proto_err", proto_err, 1'b1);
        check("early_dvalid", bus.digest_valid, 1'b1);
        check("early_state", dbg_state, DONE);
        finish_digest();
        check("proto_err_sticky", proto_err, 1'b1);
`else
        tick();
        check("early_dvalid", bus.digest_valid, 1'b0);
        check("early_hs_ready", bus.hs_ready, 1'b1);
        check("early_state", dbg_state, WAIT);
        feed(54, 8'h1A, 1);
        finish_digest();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
